// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory arbiter
package mem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Which cache currently owns the memory.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int BLOCK_BYTES = 16;
    localparam int WORD_BYTES  = 2;

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - up-counter with synchronous clear and terminal-count flag
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return count to zero next cycle (wins over inc)
//   inc        : advance count by one
//   count      : current count value
//   last       : count currently equals TERM-1
module fill_counter #(
    parameter int WIDTH = 4,
    parameter int TERM  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign last = (count == WIDTH'(TERM - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares unified memory between I-cache fills and D-cache fills/writes
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_req, i_addr                   : I-cache block fill request (held until i_done)
//   d_req, d_wr, d_addr, d_wdata    : D-cache fill or single-word write (held until d_done)
//   mem_addr/enable/wr/wdata        : memory command
//   mem_rdata, mem_data_valid       : memory read return
//   fill_data, fill_word            : returned word and its index in the block
//   i_fill_we, d_fill_we            : write the returned word into that cache
//   i_done, d_done                  : one-cycle completion pulses
//   busy                            : arbiter not idle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLOCK_BYTES - 1);

    state_t            state, state_n;
    grant_t            grant, last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [CNT_W-1:0]  issue_cnt, ret_cnt;
    logic              issue_last, ret_last;
    logic              want_d, pick_i, any_req, accept, cnt_clear;

    // D side normally wins; I wins only when D had the previous grant,
    // so a continuously requesting D-cache cannot starve the I-cache.
    assign want_d  = d_req | d_wr;
    assign pick_i  = i_req & (~want_d | (last_grant == GNT_D));
    assign any_req = i_req | want_d;

    // Returns count only while a fill owns the memory; stray or
    // post-reset returns arriving in other states are dropped.
    assign accept    = mem_data_valid & ((state == ISSUE) | (state == DRAIN));
    assign cnt_clear = (state == IDLE) | (state == DONE);

    fill_counter #(.WIDTH(CNT_W), .TERM(WORDS)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (state == ISSUE),
        .count (issue_cnt),
        .last  (issue_last)
    );

    fill_counter #(.WIDTH(CNT_W), .TERM(WORDS)) u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (accept),
        .count (ret_cnt),
        .last  (ret_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= GNT_I;
            last_grant <= GNT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= state_n;
            // Requester inputs are sampled once at grant; later changes
            // or a dropped request do not disturb the operation.
            if (state == IDLE && any_req) begin
                wdata_q <= d_wdata;
                if (pick_i) begin
                    grant  <= GNT_I;
                    addr_q <= i_addr & BASE_MASK;
                end else begin
                    grant  <= GNT_D;
                    addr_q <= d_wr ? d_addr : (d_addr & BASE_MASK);
                end
            end
            if (state == DONE) begin
                last_grant <= grant;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (pick_i)     state_n = ISSUE;
                else if (d_wr)  state_n = WRITE;
                else if (d_req) state_n = ISSUE;
            end
            WRITE:   state_n = DONE;
            ISSUE:   if (issue_last) state_n = DRAIN;
            DRAIN:   if (accept && ret_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_addr   = '0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        fill_data  = '0;
        fill_word  = '0;
        i_fill_we  = 1'b0;
        d_fill_we  = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        busy       = (state != IDLE);

        case (state)
            WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
            end
            ISSUE: begin
                mem_enable = 1'b1;
                mem_addr   = addr_q + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES);
            end
            DONE: begin
                i_done = (grant == GNT_I);
                d_done = (grant == GNT_D);
            end
            default: ;
        endcase

        if (accept) begin
            fill_data = mem_rdata;
            fill_word = 3'(ret_cnt);
            i_fill_we = (grant == GNT_I);
            d_fill_we = (grant == GNT_D);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_wr;
    logic [15:0] d_wdata;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we;
    logic        d_fill_we;
    logic        i_done;
    logic        d_done;
    logic        busy;

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_wr           (d_wr),
        .d_wdata        (d_wdata),
        .mem_addr       (mem_addr),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .i_fill_we      (i_fill_we),
        .d_fill_we      (d_fill_we),
        .i_done         (i_done),
        .d_done         (d_done),
        .busy           (busy)
    );

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        logic        side;
        logic [2:0]  word;
        logic [15:0] data;
    } fill_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    cmd_t  exp_cmd[$];
    fill_t exp_fill[$];
    logic  exp_done[$];
    ret_t  mem_q[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int n_fill   = 0;
    int done_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return {a[7:0], ~a[15:8]};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected memory commands, fill words and done pulse for one block fill.
    task automatic push_fill(input logic side, input logic [15:0] addr,
                             input int nfill, input bit with_done);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int w = 0; w < 8; w++)
            exp_cmd.push_back('{addr: base + 16'(2 * w), wr: 1'b0, wdata: 16'h0});
        for (int w = 0; w < nfill; w++)
            exp_fill.push_back('{side: side, word: 3'(w), data: mem_val(base + 16'(2 * w))});
        if (with_done) exp_done.push_back(side);
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [15:0] data);
        exp_cmd.push_back('{addr: addr, wr: 1'b1, wdata: data});
        exp_done.push_back(1'b1);
    endtask

    task automatic wait_dones(input int target, input int limit, input string tag);
        int k;
        k = 0;
        while (n_done < target && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, 36'(n_done >= target), 36'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Memory model: a read issued in cycle k returns in cycle k+MEM_LAT.
    initial begin
        mem_data_valid = 1'b0;
        mem_rdata      = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                mem_data_valid = 1'b1;
                mem_rdata      = mem_q[0].data;
                void'(mem_q.pop_front());
            end else begin
                mem_data_valid = 1'b0;
                mem_rdata      = 16'hDEAD;
            end
        end
    end

    // Monitor: compares every DUT event against the scoreboard queues.
    initial begin
        cmd_t  e;
        fill_t f;
        logic  s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outs", 36'({|mem_addr, |mem_wdata, |fill_data, |fill_word, mem_enable,
                                       mem_wr, i_fill_we, d_fill_we, i_done, d_done, busy}), 36'd0);
            end else begin
                chk("exclusive", 36'({i_fill_we & d_fill_we, i_done & d_done}), 36'd0);
                if (mem_enable) begin
                    if (exp_cmd.size() == 0) begin
                        chk("mem_unexpected", 36'(mem_enable), 36'd0);
                    end else begin
                        e = exp_cmd.pop_front();
                        if (e.wr)
                            chk("mem_write", 36'({mem_addr, mem_wr, mem_wdata}), 36'({e.addr, 1'b1, e.wdata}));
                        else
                            chk("mem_read", 36'({mem_addr, mem_wr}), 36'({e.addr, 1'b0}));
                    end
                    if (!mem_wr) mem_q.push_back('{due: cyc + MEM_LAT, data: mem_val(mem_addr)});
                end
                if (i_fill_we || d_fill_we) begin
                    if (exp_fill.size() == 0) begin
                        chk("fill_unexpected", 36'({i_fill_we, d_fill_we}), 36'd0);
                    end else begin
                        f = exp_fill.pop_front();
                        chk("fill", 36'({d_fill_we, i_fill_we, fill_word, fill_data}),
                            36'({f.side, ~f.side, f.word, f.data}));
                    end
                    n_fill++;
                end
                if (i_done || d_done) begin
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", 36'({i_done, d_done}), 36'd0);
                    end else begin
                        s = exp_done.pop_front();
                        chk("done_side", 36'({d_done, i_done}), 36'({s, ~s}));
                    end
                    n_done++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        int c0;
        int fills_before;
        int k;

        rst_n = 1'b0; i_req = 1'b0; i_addr = 16'h0;
        d_req = 1'b0; d_addr = 16'h0; d_wr = 1'b0; d_wdata = 16'h0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", 36'({busy, mem_enable, i_done, d_done, i_fill_we, d_fill_we}), 36'd0);
        rst_n = 1'b1;
        next_cycle();
        chk("idle_after_reset", 36'(busy), 36'd0);

        // I-cache fill from a mid-block address.
        c0 = cyc;
        i_req = 1'b1; i_addr = 16'h0046;
        push_fill(1'b0, 16'h0046, 8, 1'b1);
        wait_dones(1, 30, "t1_wait");
        i_req = 1'b0;
        chk("t1_latency", 36'(done_cyc - c0), 36'd13);
        chk("t1_fill_count", 36'(n_fill), 36'd8);
        next_cycle();
        chk("t1_idle", 36'(busy), 36'd0);

        // Simultaneous requests with last grant I: D first, then I.
        i_req = 1'b1; i_addr = 16'h0200;
        d_req = 1'b1; d_addr = 16'h0100;
        push_fill(1'b1, 16'h0100, 8, 1'b1);
        push_fill(1'b0, 16'h0200, 8, 1'b1);
        wait_dones(2, 30, "t2_d_wait");
        d_req = 1'b0;
        wait_dones(3, 30, "t2_i_wait");
        i_req = 1'b0;
        next_cycle();

        // Both held: grants alternate D, I, D.
        d_req = 1'b1; d_addr = 16'h0300;
        i_req = 1'b1; i_addr = 16'h0400;
        push_fill(1'b1, 16'h0300, 8, 1'b1);
        push_fill(1'b0, 16'h0400, 8, 1'b1);
        push_fill(1'b1, 16'h0300, 8, 1'b1);
        wait_dones(4, 30, "t4_first");
        wait_dones(5, 30, "t4_second");
        wait_dones(6, 30, "t4_third");
        d_req = 1'b0; i_req = 1'b0;
        next_cycle();

        // Single-word write-through.
        fills_before = n_fill;
        c0 = cyc;
        d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
        push_write(16'h1234, 16'hBEEF);
        wait_dones(7, 10, "t3_wait");
        d_wr = 1'b0;
        chk("t3_latency", 36'(done_cyc - c0), 36'd2);
        chk("t3_no_fill", 36'(n_fill), 36'(fills_before));
        next_cycle();

        // Requester address changes mid-fill; latched base is kept.
        d_req = 1'b1; d_addr = 16'h2000;
        push_fill(1'b1, 16'h2000, 8, 1'b1);
        repeat (3) next_cycle();
        d_addr = 16'h3000;
        wait_dones(8, 30, "t6_wait");
        d_req = 1'b0;
        next_cycle();

        // Reset in DRAIN after five returns; remaining returns must be ignored.
        fills_before = n_fill;
        i_req = 1'b1; i_addr = 16'h0500;
        push_fill(1'b0, 16'h0500, 5, 1'b0);
        k = 0;
        while (n_fill < fills_before + 5 && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t5_five_returns", 36'(n_fill - fills_before), 36'd5);
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear", 36'({busy, mem_enable, i_fill_we, d_fill_we, i_done, d_done, |fill_data}), 36'd0);
        i_req = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (6) next_cycle();
        chk("t5_no_done", 36'(n_done), 36'd8);
        chk("t5_no_stray_fill", 36'(n_fill - fills_before), 36'd5);

        // Fresh request after reset starts at word 0.
        i_req = 1'b1; i_addr = 16'h0600;
        push_fill(1'b0, 16'h0600, 8, 1'b1);
        wait_dones(9, 30, "t5_fresh_wait");
        i_req = 1'b0;
        repeat (3) next_cycle();

        chk("left_cmds", 36'(exp_cmd.size()), 36'd0);
        chk("left_fills", 36'(exp_fill.size()), 36'd0);
        chk("left_dones", 36'(exp_done.size()), 36'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
